// File: rtl/cdu_pulse_scheduler.sv
// -----------------------------------------------------------------------------
// cdu_pulse_scheduler
//
// Shares the single AGC counter-pulse slot between the CDU read-counter
// channels. Each channel's up/down angle increments are accumulated into a
// signed, saturating pending count. Once per arbitration slot, one channel
// with a nonzero pending count is granted in round-robin order. The granted
// channel then receives a fixed-width PLUS or MINUS pulse, which moves its
// pending count one step toward zero.
//
// Parameters
//   NCHAN       number of requesting channels
//   SLOT_CYCLES CLOCKH cycles per arbitration slot (must exceed PULSE_W+1)
//   PULSE_W     width of each AGC pulse in CLOCKH cycles
//   PEND_W      signed pending-counter width per channel
//
// Ports
//   CLOCKH  in   system clock, rising edge
//   rst_n   in   asynchronous active-low reset
//   DRVEN   in   global drive enable; low inhibits new grants
//   UPREQ   in   [NCHAN] single-cycle up-increment request per channel
//   DNREQ   in   [NCHAN] single-cycle down-increment request per channel
//   CDUZ    in   [NCHAN] per-channel zero (level)
//   PLSP    out  [NCHAN] AGC plus pulse per channel (registered)
//   PLSM    out  [NCHAN] AGC minus pulse per channel (registered)
//   GRANT   out  [NCHAN] one-hot grant, high during the decision cycle only
//   OVF     out  [NCHAN] sticky pending-overflow flag per channel (registered)
//   BUSY    out  any pending count nonzero or a pulse in flight (registered)
// -----------------------------------------------------------------------------
module cdu_pulse_scheduler #(
  parameter int NCHAN       = 3,
  parameter int SLOT_CYCLES = 8,
  parameter int PULSE_W     = 2,
  parameter int PEND_W      = 6
) (
  input  logic             CLOCKH,
  input  logic             rst_n,
  input  logic             DRVEN,
  input  logic [NCHAN-1:0] UPREQ,
  input  logic [NCHAN-1:0] DNREQ,
  input  logic [NCHAN-1:0] CDUZ,
  output logic [NCHAN-1:0] PLSP,
  output logic [NCHAN-1:0] PLSM,
  output logic [NCHAN-1:0] GRANT,
  output logic [NCHAN-1:0] OVF,
  output logic             BUSY
);

  localparam int SLOT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int PTR_W  = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int PW_W   = $clog2(PULSE_W + 1);
  // Two guard bits hold the worst-case unsaturated result (max + 1 + 1).
  localparam int SUM_W  = PEND_W + 2;

  localparam logic signed [PEND_W-1:0] PEND_MAX = {1'b0, {(PEND_W-1){1'b1}}};
  localparam logic signed [PEND_W-1:0] PEND_MIN = -PEND_MAX;
  localparam logic signed [SUM_W-1:0]  MAX_S    = SUM_W'(PEND_MAX);
  localparam logic signed [SUM_W-1:0]  MIN_S    = SUM_W'(PEND_MIN);
  localparam logic signed [SUM_W-1:0]  ONE_S    = SUM_W'(1'b1);

  // State registers
  logic [SLOT_W-1:0]        slot_r;
  logic [PTR_W-1:0]         ptr_r;
  logic signed [PEND_W-1:0] pend_r [NCHAN];
  logic [NCHAN-1:0]         ovf_r;
  logic [NCHAN-1:0]         plsp_r;
  logic [NCHAN-1:0]         plsm_r;
  logic [PW_W-1:0]          pw_r;
  logic                     busy_r;

  // Next-state / decode signals
  logic [NCHAN-1:0]         elig_s;
  logic [NCHAN-1:0]         grant_s;
  logic                     found_s;
  logic                     gpos_s;
  logic [PTR_W-1:0]         ptr_n_s;
  logic signed [SUM_W-1:0]  sum_s    [NCHAN];
  logic signed [PEND_W-1:0] pend_n_s [NCHAN];
  logic [NCHAN-1:0]         ovf_n_s;
  logic                     any_pend_s;
  logic [NCHAN-1:0]         plsp_n_s;
  logic [NCHAN-1:0]         plsm_n_s;
  logic [PW_W-1:0]          pw_n_s;
  logic [SLOT_W-1:0]        slot_n_s;
  logic                     busy_n_s;

  // Per-channel eligibility, excluding the global drive enable.
  always_comb begin
    elig_s = '0;
    for (int i = 0; i < NCHAN; i++) begin
      elig_s[i] = (pend_r[i] != '0) && !CDUZ[i];
    end
  end

  // Round-robin search from the pointer, only in the decision cycle (slot 0).
  // GRANT is decoded during the decision cycle itself. The pulse it launches
  // is registered and starts on the following cycle.
  always_comb begin
    grant_s = '0;
    found_s = 1'b0;
    gpos_s  = 1'b0;
    ptr_n_s = ptr_r;
    if ((slot_r == '0) && DRVEN) begin
      for (int k = 0; k < NCHAN; k++) begin
        for (int i = 0; i < NCHAN; i++) begin
          if (!found_s && elig_s[i] && (i == ((int'(ptr_r) + k) % NCHAN))) begin
            found_s    = 1'b1;
            grant_s[i] = 1'b1;
            // Sign comes from the registered count, before this cycle's update.
            gpos_s     = ~pend_r[i][PEND_W-1];
            ptr_n_s    = (i == NCHAN - 1) ? '0 : PTR_W'(i + 1);
          end else begin
            found_s = found_s;
          end
        end
      end
    end else begin
      grant_s = '0;
    end
  end

  // Pending accumulate with grant consumption, zero hold and saturation.
  always_comb begin
    any_pend_s = 1'b0;
    ovf_n_s    = ovf_r;
    for (int i = 0; i < NCHAN; i++) begin
      sum_s[i] = SUM_W'(pend_r[i]);
      if (UPREQ[i] && !DNREQ[i]) begin
        sum_s[i] = sum_s[i] + ONE_S;
      end else if (DNREQ[i] && !UPREQ[i]) begin
        sum_s[i] = sum_s[i] - ONE_S;
      end else begin
        sum_s[i] = sum_s[i];
      end
      // A grant moves the count one step toward zero.
      if (grant_s[i]) begin
        if (pend_r[i][PEND_W-1]) begin
          sum_s[i] = sum_s[i] + ONE_S;
        end else begin
          sum_s[i] = sum_s[i] - ONE_S;
        end
      end else begin
        sum_s[i] = sum_s[i];
      end
      if (CDUZ[i]) begin
        pend_n_s[i] = '0;
        ovf_n_s[i]  = 1'b0;
      end else if (sum_s[i] > MAX_S) begin
        pend_n_s[i] = PEND_MAX;
        ovf_n_s[i]  = 1'b1;
      end else if (sum_s[i] < MIN_S) begin
        pend_n_s[i] = PEND_MIN;
        ovf_n_s[i]  = 1'b1;
      end else begin
        pend_n_s[i] = sum_s[i][PEND_W-1:0];
        ovf_n_s[i]  = ovf_r[i];
      end
      any_pend_s = any_pend_s | (pend_n_s[i] != '0);
    end
  end

  // Pulse generator. pw_r counts the remaining high cycles after the current
  // one. Neither DRVEN nor CDUZ can cut a pulse short.
  always_comb begin
    plsp_n_s = plsp_r;
    plsm_n_s = plsm_r;
    pw_n_s   = pw_r;
    if (found_s) begin
      plsp_n_s = gpos_s ? grant_s : '0;
      plsm_n_s = gpos_s ? '0 : grant_s;
      pw_n_s   = PW_W'(PULSE_W - 1);
    end else if (pw_r != '0) begin
      pw_n_s = pw_r - PW_W'(1'b1);
    end else begin
      plsp_n_s = '0;
      plsm_n_s = '0;
      pw_n_s   = '0;
    end
  end

  // Slot counter wrap and BUSY look-ahead, so BUSY tracks the state it describes.
  always_comb begin
    if (slot_r == SLOT_W'(SLOT_CYCLES - 1)) begin
      slot_n_s = '0;
    end else begin
      slot_n_s = slot_r + SLOT_W'(1'b1);
    end
    busy_n_s = any_pend_s | (|(plsp_n_s | plsm_n_s));
  end

  // State and registered-output update.
  always_ff @(posedge CLOCKH or negedge rst_n) begin
    if (!rst_n) begin
      slot_r <= '0;
      ptr_r  <= '0;
      ovf_r  <= '0;
      plsp_r <= '0;
      plsm_r <= '0;
      pw_r   <= '0;
      busy_r <= 1'b0;
      for (int i = 0; i < NCHAN; i++) begin
        pend_r[i] <= '0;
      end
    end else begin
      slot_r <= slot_n_s;
      ptr_r  <= ptr_n_s;
      ovf_r  <= ovf_n_s;
      plsp_r <= plsp_n_s;
      plsm_r <= plsm_n_s;
      pw_r   <= pw_n_s;
      busy_r <= busy_n_s;
      for (int i = 0; i < NCHAN; i++) begin
        pend_r[i] <= pend_n_s[i];
      end
    end
  end

  assign PLSP  = plsp_r;
  assign PLSM  = plsm_r;
  assign GRANT = grant_s;
  assign OVF   = ovf_r;
  assign BUSY  = busy_r;

endmodule

// File: tb/tb_cdu_pulse_scheduler.sv
// -----------------------------------------------------------------------------
// tb_cdu_pulse_scheduler
//
// Self-checking bench for cdu_pulse_scheduler (NCHAN=3, SLOT_CYCLES=8,
// PULSE_W=2, PEND_W=6). A cycle-level reference model pushes each cycle's
// expected outputs into a scoreboard queue as inputs are driven. The entry is
// popped and compared on the falling edge. A table of scenario phases holds
// hand-derived pulse totals and end-of-phase flags. Hand-written sequences
// cover zeroing during a pulse and reset in the middle of a pulse.
// -----------------------------------------------------------------------------
module tb_cdu_pulse_scheduler;

  localparam int NCH  = 3;
  localparam int SLOT = 8;
  localparam int PW   = 2;
  localparam int PMAX = 31;

  logic       CLOCKH = 1'b0;
  logic       rst_n  = 1'b0;
  logic       DRVEN  = 1'b0;
  logic [2:0] UPREQ  = 3'b000;
  logic [2:0] DNREQ  = 3'b000;
  logic [2:0] CDUZ   = 3'b000;
  logic [2:0] PLSP, PLSM, GRANT, OVF;
  logic       BUSY;

  always #5 CLOCKH = ~CLOCKH;

  cdu_pulse_scheduler #(.NCHAN(NCH), .SLOT_CYCLES(SLOT), .PULSE_W(PW), .PEND_W(6)) dut (
    .CLOCKH(CLOCKH), .rst_n(rst_n), .DRVEN(DRVEN), .UPREQ(UPREQ), .DNREQ(DNREQ),
    .CDUZ(CDUZ), .PLSP(PLSP), .PLSM(PLSM), .GRANT(GRANT), .OVF(OVF), .BUSY(BUSY)
  );

  typedef struct packed {
    logic [2:0] grant;
    logic [2:0] plsp;
    logic [2:0] plsm;
    logic [2:0] ovf;
    logic       busy;
  } exp_t;

  typedef struct {
    logic [2:0] up, dn, cduz;
    logic       drven;
    int         req_n, idle_n;
    int         p0, p1, p2, m0, m1, m2;
    logic [2:0] ovf;
    logic       busy;
  } phase_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state
  int         m_pend [3];
  int         m_cnt, m_ptr, m_left, m_chan;
  bit         m_pos;
  logic [2:0] m_ovf;

  // Observation state
  int         starts_p [3];
  int         starts_m [3];
  int         run_p [3];
  int         run_m [3];
  logic [2:0] first_grant;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_pend[i] = 0; run_p[i] = 0; run_m[i] = 0;
    end
    m_cnt = 0; m_ptr = 0; m_left = 0; m_chan = 0; m_pos = 1'b0; m_ovf = 3'b000;
  endtask

  function automatic logic [2:0] model_grant(input logic [2:0] cduz, input logic drven);
    logic [2:0] one;
    one = 3'b001;
    if (m_cnt != 0 || !drven) return 3'b000;
    for (int k = 0; k < 3; k++) begin
      int c;
      c = (m_ptr + k) % 3;
      if (m_pend[c] != 0 && !cduz[c]) return one << c;
    end
    return 3'b000;
  endfunction

  task automatic model_update(input logic [2:0] up, dn, cduz, input logic [2:0] grant);
    int g;
    int s;
    g = -1;
    for (int i = 0; i < 3; i++) if (grant[i]) g = i;
    if (g >= 0) begin
      m_pos  = (m_pend[g] > 0);
      m_chan = g;
      m_left = PW;
      m_ptr  = (g + 1) % 3;
    end else if (m_left > 0) begin
      m_left--;
    end
    for (int i = 0; i < 3; i++) begin
      if (cduz[i]) begin
        m_pend[i] = 0;
        m_ovf[i]  = 1'b0;
      end else begin
        s = m_pend[i] + int'(up[i]) - int'(dn[i]);
        if (i == g) s = s - ((m_pend[i] > 0) ? 1 : -1);
        if (s > PMAX) begin
          s = PMAX; m_ovf[i] = 1'b1;
        end else if (s < -PMAX) begin
          s = -PMAX; m_ovf[i] = 1'b1;
        end
        m_pend[i] = s;
      end
    end
    m_cnt = (m_cnt + 1) % SLOT;
  endtask

  // One clock cycle: drive, predict, compare at negedge, advance model at posedge.
  task automatic cycle(input logic [2:0] up, dn, cduz, input logic drven);
    exp_t e, got, want;
    logic [2:0] one;
    one   = 3'b001;
    UPREQ = up; DNREQ = dn; CDUZ = cduz; DRVEN = drven;
    e.grant = model_grant(cduz, drven);
    e.plsp  = (m_left > 0 && m_pos)  ? (one << m_chan) : 3'b000;
    e.plsm  = (m_left > 0 && !m_pos) ? (one << m_chan) : 3'b000;
    e.ovf   = m_ovf;
    e.busy  = (m_pend[0] != 0) || (m_pend[1] != 0) || (m_pend[2] != 0) || (m_left > 0);
    exp_q.push_back(e);
    @(negedge CLOCKH);
    got  = {GRANT, PLSP, PLSM, OVF, BUSY};
    want = exp_q.pop_front();
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL cycle_outputs t=%0t: got grant=%b plsp=%b plsm=%b ovf=%b busy=%b, expected grant=%b plsp=%b plsm=%b ovf=%b busy=%b",
               $time, got.grant, got.plsp, got.plsm, got.ovf, got.busy,
               want.grant, want.plsp, want.plsm, want.ovf, want.busy);
    end
    if (GRANT != 3'b000 && first_grant == 3'b000) first_grant = GRANT;
    for (int i = 0; i < 3; i++) begin
      if (PLSP[i]) begin
        if (run_p[i] == 0) starts_p[i]++;
        run_p[i]++;
      end else if (run_p[i] > 0) begin
        check($sformatf("plsp%0d_width", i), run_p[i], PW);
        run_p[i] = 0;
      end
      if (PLSM[i]) begin
        if (run_m[i] == 0) starts_m[i]++;
        run_m[i]++;
      end else if (run_m[i] > 0) begin
        check($sformatf("plsm%0d_width", i), run_m[i], PW);
        run_m[i] = 0;
      end
    end
    @(posedge CLOCKH);
    model_update(up, dn, cduz, e.grant);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_plsp"},  int'(PLSP),  0);
    check({tag, "_plsm"},  int'(PLSM),  0);
    check({tag, "_grant"}, int'(GRANT), 0);
    check({tag, "_ovf"},   int'(OVF),   0);
    check({tag, "_busy"},  int'(BUSY),  0);
  endtask

  function automatic phase_t mk(input logic [2:0] up, dn, cduz, input logic drven,
                                input int req_n, idle_n, p0, p1, p2, m0, m1, m2,
                                input logic [2:0] ovf, input logic busy);
    phase_t p;
    p.up = up; p.dn = dn; p.cduz = cduz; p.drven = drven;
    p.req_n = req_n; p.idle_n = idle_n;
    p.p0 = p0; p.p1 = p1; p.p2 = p2; p.m0 = m0; p.m1 = m1; p.m2 = m2;
    p.ovf = ovf; p.busy = busy;
    return p;
  endfunction

  phase_t tbl [7];

  initial begin
    int sp [3];
    int sm [3];
    bit seen;

    // up   dn   cduz drv req idle  p0 p1 p2  m0 m1 m2  ovf busy
    tbl[0] = mk(3'b001, 3'b000, 3'b000, 1'b1,  1,  24, 1, 0, 0,  0, 0, 0, 3'b000, 1'b0); // single up on ch0
    tbl[1] = mk(3'b100, 3'b010, 3'b000, 1'b1,  2,   0, 0, 0, 0,  0, 0, 0, 3'b000, 1'b1); // 2 up ch2 + 2 dn ch1
    tbl[2] = mk(3'b000, 3'b010, 3'b000, 1'b1,  1,  60, 0, 0, 2,  0, 3, 0, 3'b000, 1'b0); // 3rd dn ch1, drain
    tbl[3] = mk(3'b001, 3'b001, 3'b000, 1'b1,  3,  10, 0, 0, 0,  0, 0, 0, 3'b000, 1'b0); // up+dn cancel
    tbl[4] = mk(3'b100, 3'b000, 3'b000, 1'b0, 40,   0, 0, 0, 0,  0, 0, 0, 3'b100, 1'b1); // saturate ch2
    tbl[5] = mk(3'b000, 3'b000, 3'b000, 1'b1,  0, 264, 0, 0, 31, 0, 0, 0, 3'b100, 1'b0); // drain 31
    tbl[6] = mk(3'b000, 3'b000, 3'b100, 1'b1,  0,   2, 0, 0, 0,  0, 0, 0, 3'b000, 1'b0); // zero clears OVF

    for (int i = 0; i < 3; i++) begin
      starts_p[i] = 0; starts_m[i] = 0;
    end
    first_grant = 3'b000;
    model_reset();

    // Reset state
    @(posedge CLOCKH); #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Table-driven phases
    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < 3; i++) begin
        sp[i] = starts_p[i]; sm[i] = starts_m[i];
      end
      for (int c = 0; c < tbl[t].req_n; c++) cycle(tbl[t].up, tbl[t].dn, tbl[t].cduz, tbl[t].drven);
      for (int c = 0; c < tbl[t].idle_n; c++) cycle(3'b000, 3'b000, tbl[t].cduz, tbl[t].drven);
      check($sformatf("ph%0d_plsp0", t), starts_p[0] - sp[0], tbl[t].p0);
      check($sformatf("ph%0d_plsp1", t), starts_p[1] - sp[1], tbl[t].p1);
      check($sformatf("ph%0d_plsp2", t), starts_p[2] - sp[2], tbl[t].p2);
      check($sformatf("ph%0d_plsm0", t), starts_m[0] - sm[0], tbl[t].m0);
      check($sformatf("ph%0d_plsm1", t), starts_m[1] - sm[1], tbl[t].m1);
      check($sformatf("ph%0d_plsm2", t), starts_m[2] - sm[2], tbl[t].m2);
      check($sformatf("ph%0d_ovf", t),  int'(OVF),  int'(tbl[t].ovf));
      check($sformatf("ph%0d_busy", t), int'(BUSY), int'(tbl[t].busy));
    end

    // CDUZ[1] asserted during a PLSM[1] pulse with pending[1] = -5
    for (int c = 0; c < 5; c++) cycle(3'b000, 3'b010, 3'b000, 1'b0);
    sm[1] = starts_m[1]; sp[1] = starts_p[1];
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      cycle(3'b000, 3'b000, 3'b000, 1'b1);
      seen = (starts_m[1] != sm[1]);
    end
    check("zero_pulse_seen", int'(seen), 1);
    for (int c = 0; c < 4; c++) cycle(3'b010, 3'b000, 3'b010, 1'b1);
    for (int c = 0; c < 4; c++) cycle(3'b000, 3'b010, 3'b010, 1'b1);
    for (int c = 0; c < 24; c++) cycle(3'b000, 3'b000, 3'b000, 1'b1);
    check("zero_plsm1_count", starts_m[1] - sm[1], 1);
    check("zero_plsp1_count", starts_p[1] - sp[1], 0);
    check("zero_busy", int'(BUSY), 0);

    // Reset in the middle of a PLSP[0] pulse
    for (int c = 0; c < 3; c++) cycle(3'b001, 3'b000, 3'b000, 1'b0);
    sp[0] = starts_p[0];
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      cycle(3'b000, 3'b000, 3'b000, 1'b1);
      seen = (starts_p[0] != sp[0]);
    end
    check("rst_pulse_seen", int'(seen), 1);
    check("rst_plsp_before", int'(PLSP), 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    model_reset();
    @(posedge CLOCKH); #1;
    check_all_zero("held_rst");
    @(posedge CLOCKH); #1;
    rst_n = 1'b1;

    // After release the pointer starts at channel 0.
    first_grant = 3'b000;
    cycle(3'b101, 3'b000, 3'b000, 1'b1);
    for (int c = 0; c < 30; c++) cycle(3'b000, 3'b000, 3'b000, 1'b1);
    check("post_rst_first_grant", int'(first_grant), 1);
    check("post_rst_busy", int'(BUSY), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
